// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM.
// Sequences the shared datapath (PC, memory, register file, ALU, PC mux) over
// several cycles per instruction. Memory accesses stall on mem_ready.
// A retired-instruction counter is kept for bring-up and performance checks.
// Optional: define ILLEGAL_TRAP_EN to send illegal opcodes to a sticky TRAP
// state; otherwise they retire as NOPs from DECODE.
module mips_multicycle_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter logic [5:0]  OP_RTYPE = 6'b000000,
  parameter logic [5:0]  OP_LW    = 6'b100011,
  parameter logic [5:0]  OP_SW    = 6'b101011,
  parameter logic [5:0]  OP_BEQ   = 6'b000100,
  parameter logic [5:0]  OP_J     = 6'b000010
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_out,
  output logic             trap
);

  typedef enum logic [3:0] {
    StReset  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10
`ifdef ILLEGAL_TRAP_EN
    ,
    StTrap   = 4'd11
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             op_legal;

  assign op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ) || (opcode == OP_J);

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= StReset;
    else          state_q <= state_d;
  end

  // Retired-instruction counter, wraps silently
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)    count_q <= '0;
    else if (retire) count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:  state_d = StFetch;
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        if (!op_legal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = StTrap;
`else
          state_d = StFetch;
`endif
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = StMemAdr;
        end else if (opcode == OP_RTYPE) begin
          state_d = StExec;
        end else if (opcode == OP_BEQ) begin
          state_d = StBranch;
        end else begin
          state_d = StJump;
        end
      end
      StMemAdr: state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
`ifdef ILLEGAL_TRAP_EN
      StTrap:   state_d = StTrap;
`endif
      default:  state_d = StReset;
    endcase
  end

  // Moore output decode; only handshake and branch terms look at inputs
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    trap       = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      StDecode: begin
        alu_src_b = 2'b11;
`ifndef ILLEGAL_TRAP_EN
        retire    = ~op_legal;
`endif
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        retire  = mem_ready;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = zero;
        retire    = 1'b1;
      end
      StJump: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
        retire = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      StTrap: trap = 1'b1;
`endif
      default: ;
    endcase
  end

  assign instr_count = count_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl against an instruction-level model:
// each instruction expands into its list of steps, memory steps repeat while
// mem_ready is low, and per-step outputs come from a table.
module tb_mips_multicycle_ctrl;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [5:0]    opcode;
  logic          zero, mem_ready;
  logic          mem_req, mem_we, iord, ir_write, pc_en, alu_src_a;
  logic [1:0]    pc_src, alu_src_b, alu_op;
  logic          reg_write, reg_dst, mem_to_reg, retire, trap;
  logic [CW-1:0] instr_count;
  logic [3:0]    state_out;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_write, reg_dst, mem_to_reg, retire, trap;
  } outs_t;

  outs_t dut_o;
  assign dut_o = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
                  alu_op, reg_write, reg_dst, mem_to_reg, retire, trap};

  always #5 CLK = ~CLK;

  mips_multicycle_ctrl #(.CNT_W(CW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .retire(retire),
    .instr_count(instr_count), .state_out(state_out), .trap(trap)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 || op == 6'd2;
  endfunction

  // Step lists use the visible state numbering
  function automatic void build(input logic [5:0] op, output int q[$]);
    case (op)
      6'd0:    q = '{1, 2, 7, 8};
      6'd35:   q = '{1, 2, 3, 4, 5};
      6'd43:   q = '{1, 2, 3, 6};
      6'd4:    q = '{1, 2, 9};
      6'd2:    q = '{1, 2, 10};
`ifdef ILLEGAL_TRAP_EN
      default: q = '{1, 2, 11};
`else
      default: q = '{1, 2};
`endif
    endcase
  endfunction

  // Zero-wait cycle counts
  function automatic int base_cycles(input logic [5:0] op);
    case (op)
      6'd0:    return 4;
      6'd35:   return 5;
      6'd43:   return 4;
      6'd4:    return 3;
      6'd2:    return 3;
      default: return 2;
    endcase
  endfunction

  function automatic outs_t exp_outs(input int st, input logic z, input logic rdy,
                                     input logic [5:0] op);
    outs_t o;
    o = '0;
    case (st)
      1:  begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_en = rdy; end
      2:  begin
        o.alu_src_b = 2'b11;
`ifndef ILLEGAL_TRAP_EN
        o.retire = !legal(op);
`endif
      end
      3:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4:  begin o.mem_req = 1; o.iord = 1; end
      5:  begin o.reg_write = 1; o.mem_to_reg = 1; o.retire = 1; end
      6:  begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; o.retire = rdy; end
      7:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      8:  begin o.reg_write = 1; o.reg_dst = 1; o.retire = 1; end
      9:  begin
        o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_en = z; o.retire = 1;
      end
      10: begin o.pc_src = 2'b10; o.pc_en = 1; o.retire = 1; end
      11: o.trap = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic [5:0] pick();
    int r;
    r = $urandom_range(0, 15);
    if (r < 3)       return 6'd0;
    else if (r < 6)  return 6'd35;
    else if (r < 9)  return 6'd43;
    else if (r < 12) return 6'd4;
    else if (r < 14) return 6'd2;
    else if (r == 14) return 6'b111111;
    else             return 6'b001000;
  endfunction

  int            sched[$];
  logic [CW-1:0] m_count;
  logic [5:0]    op;
  outs_t         e;
  int            st, cyc, start_cyc, waits, inst_num, trap_cyc;
  bit            reset_due, wrap_done, stall, do_rst;

  initial begin
    opcode = '0; zero = 0; mem_ready = 0; RESET_N = 1;
    op = '0; inst_num = 0; trap_cyc = 0; reset_due = 0; wrap_done = 0;
    start_cyc = 0; waits = 0;
    #2 RESET_N = 0;
    #1;
    chk("rst_state", state_out, 0);
    chk("rst_outs", dut_o, 0);
    chk("rst_count", instr_count, 0);
    @(posedge CLK); #1;
    chk("rst_hold", state_out, 0);
    RESET_N = 1;
    sched = '{0};
    m_count = '0;
    cyc = 0;

    for (int it = 0; it < 3000; it++) begin
      if (sched.size() == 0) begin
        inst_num++;
        if (inst_num == 17 && !wrap_done) begin
          // 16 jumps from reset: counter wraps, 1 + 16*3 cycles elapsed
          chk("wrap_count", instr_count, 0);
          chk("wrap_cycles", cyc, 49);
          wrap_done = 1;
        end
        op = (inst_num <= 16) ? 6'd2 : pick();
        opcode = op;
        build(op, sched);
        start_cyc = cyc;
        waits = 0;
        reset_due = reset_due || (inst_num == 40) || ($urandom_range(0, 24) == 0);
      end
      st = sched[0];
      mem_ready = (inst_num <= 16) ? 1'b1 : ($urandom_range(0, 2) != 0);
      zero = 1'($urandom_range(0, 1));
      #1;
      e = exp_outs(st, zero, mem_ready, op);
      chk("state", state_out, st);
      chk("outs", dut_o, e);
      chk("count", instr_count, m_count);
      chk("pc_en_and_reg_write", pc_en & reg_write, 0);

      do_rst = 0;
      if (st == 4 && reset_due && inst_num > 16) do_rst = 1;
      if (st == 11) begin
        trap_cyc++;
        if (trap_cyc == 10) do_rst = 1;
      end

      if (do_rst) begin
        #1 RESET_N = 0;
        #1;
        chk("async_state", state_out, 0);
        chk("async_outs", dut_o, 0);
        chk("async_count", instr_count, 0);
        @(posedge CLK); #1;
        RESET_N = 1;
        sched = '{0};
        m_count = '0;
        trap_cyc = 0;
        reset_due = 0;
        cyc++;
      end else begin
        stall = (st == 1 || st == 4 || st == 6) && !mem_ready;
        if (stall) waits++;
        if (e.retire) begin
          m_count = m_count + 1'b1;
          chk("latency", cyc - start_cyc + 1, base_cycles(op) + waits);
        end
        if (!stall && st != 11) void'(sched.pop_front());
        cyc++;
        @(posedge CLK); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM that sequences the shared MIPS datapath (PC, instruction/data memory, register file, ALU, PC mux) over multiple cycles per instruction. It replaces the per-opcode combinational steering with a single shared-ALU, shared-memory schedule. Memory accesses use a req/ready handshake so variable-latency memory can stall the sequence. A retired-instruction counter is included for bring-up and performance checks.

Parameters:
CNT_W, 32, width of the retired-instruction counter
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-on-equal opcode
OP_J, 6'b000010, jump opcode

Ports:
CLK  in  1  clock, all state updates on posedge
RESET_N  in  1  asynchronous active-low reset
opcode  in  6  instruction[31:26] from the instruction register
zero  in  1  ALU zero flag (rs == rt for BEQ)
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  1 = write (store), 0 = read
iord  out  1  memory address select: 0 = PC, 1 = ALU result
ir_write  out  1  latch fetched instruction
pc_en  out  1  PC register load enable
pc_src  out  2  00 = ALU (PC+4), 01 = branch target register, 10 = jump address
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
alu_op  out  2  00 = add, 01 = subtract, 10 = decode funct
reg_write  out  1  register file write enable
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALU result, 1 = memory data
retire  out  1  one-cycle pulse on the last cycle of every instruction
instr_count  out  CNT_W  retired-instruction count
state_out  out  4  current state encoding (debug)
trap  out  1  illegal-opcode indication (see Optional Feature)

Behaviour:
- State encoding: RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, TRAP=11.
- Outputs are Moore decodes of the state register, except where a term is gated by mem_ready or zero. Any output not listed for a state is 0.
- Reset (async, any time, including mid-access): state=RESET, instr_count=0. All outputs are 0 while in RESET. The first posedge after reset is released moves to FETCH.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. Hold while mem_ready=0. When mem_ready=1: ir_write=1, pc_en=1, next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - LW or SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ -> BRANCH
  - J -> JUMP
  - any other opcode -> illegal handling (see Optional Feature)
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMRD if LW, else MEMWR.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. retire=1. Next state FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. Hold until mem_ready=1; on that cycle retire=1 and next state FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. retire=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. retire=1. Next state FETCH.
- JUMP: pc_src=10, pc_en=1. retire=1. Next state FETCH.
- Cycle counts with zero-wait memory: R-type 4, LW 5, SW 4, BEQ 3, J 3. Each cycle mem_ready is held low adds exactly one cycle.
- mem_ready is ignored in states where mem_req=0.
- opcode must stay stable from DECODE until retire; the FSM samples it in DECODE and again in MEMADR.
- instr_count increments on the same posedge that ends a cycle with retire=1. It wraps 2^CNT_W-1 -> 0 with no flag.
- pc_en and reg_write are never both asserted in the same cycle.

Optional Feature:
ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE goes to TRAP. In TRAP, trap=1, all other outputs are 0, and there is no retire. TRAP is left only by reset.
- Undefined: an illegal opcode executes as a NOP: DECODE -> FETCH with retire=1 on the DECODE cycle. The TRAP state does not exist and trap is tied to 0.

Test Plan:
- Reset: assert RESET_N=0 mid-MEMRD -> state_out=0, all outputs 0, instr_count=0 immediately. After release, FETCH follows on the next edge.
- R-type, mem_ready tied 1: opcode=000000 -> state sequence 1,2,7,8. reg_write=1 and reg_dst=1 in cycle 4. instr_count goes 0->1.
- LW with 2 wait cycles in MEMRD: opcode=100011, mem_ready=0 for 2 cycles -> MEMRD held for 3 cycles, total 7 cycles. mem_to_reg=1 in MEMWB.
- BEQ: zero=1 -> pc_en=1 with pc_src=01 in BRANCH. zero=0 -> pc_en=0 in BRANCH. Each case takes 3 cycles.
- SW then J back-to-back: SW asserts mem_we=1 only in MEMWR. J asserts pc_src=10 and pc_en=1. instr_count increases by 2.
- Illegal opcode 6'b111111: with ILLEGAL_TRAP_EN, trap=1 and the FSM stays in state 11 for 10 cycles. Without it, retire pulses in DECODE and the next state is FETCH.
- Counter wrap: CNT_W=4, retire 16 instructions -> instr_count returns to 0.
